// File: rtl/sysbus_mem_responder_pkg.sv
// Shared types and constants for the SysBus memory responder slice.
package sysbus_mem_responder_pkg;

    localparam int SYSBUS_DATA_W = 16;

    // Word offsets of the I/O registers relative to IO_BASE.
    localparam int IO_SW_OFS  = 0;
    localparam int IO_LED_OFS = 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ADDR  = 2'd1,
        READ  = 2'd2,
        WDONE = 2'd3
    } bus_state_t;

endpackage

// File: rtl/sysbus_mem_responder_if.sv
// Multiplexed SysBus between the CPU (master) and the memory responder (slave).
interface sysbus_mem_responder_if
    import sysbus_mem_responder_pkg::*;
#(
    parameter int DATA_W = SYSBUS_DATA_W
);
    // Protocol: ALE high for one cycle puts an address on SysBusIn. After that,
    // with nME low, nOE low requests a read (data driven while SysBusOe is high)
    // and nWE low requests a write of SysBusIn. Both strobes low is an error.
    logic [DATA_W-1:0] SysBusIn;
    logic [DATA_W-1:0] SysBusOut;
    logic              SysBusOe;
    logic              ALE;
    logic              nME;
    logic              nOE;
    logic              nWE;

    modport master (
        output SysBusIn, ALE, nME, nOE, nWE,
        input  SysBusOut, SysBusOe
    );

    modport slave (
        input  SysBusIn, ALE, nME, nOE, nWE,
        output SysBusOut, SysBusOe
    );

endinterface

// File: rtl/sysbus_mem_responder_ram.sv
// Single-port word RAM: synchronous write, combinational read, no reset.
module sysbus_ram #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 16
) (
    input  logic              Clock,
    input  logic              We,
    input  logic [ADDR_W-1:0] Addr,
    input  logic [DATA_W-1:0] WData,
    output logic [DATA_W-1:0] RData
);

    logic [DATA_W-1:0] mem [2**ADDR_W];

    always_ff @(posedge Clock) begin
        if (We) mem[Addr] <= WData;
    end

    assign RData = mem[Addr];

endmodule

// File: rtl/sysbus_mem_responder.sv
// SysBus memory responder: address latch, strobe FSM, RAM and I/O register decode.
module sysbus_mem_responder
    import sysbus_mem_responder_pkg::*;
#(
    parameter int                ADDR_W  = 10,
    parameter int                DATA_W  = SYSBUS_DATA_W,
    parameter logic [DATA_W-1:0] IO_BASE = 16'hFFF0
) (
    input  logic                   Clock,
    input  logic                   nReset,
    sysbus_mem_responder_if.slave  bus,
    input  logic [DATA_W-1:0]      Switches,
    output logic [DATA_W-1:0]      Leds,
    output logic                   BusErr,
    output bus_state_t             StateDbg
);

    localparam logic [DATA_W-1:0] SW_ADDR  = DATA_W'(int'(IO_BASE) + IO_SW_OFS);
    localparam logic [DATA_W-1:0] LED_ADDR = DATA_W'(int'(IO_BASE) + IO_LED_OFS);

    if (int'(IO_BASE) < (1 << ADDR_W)) begin : gIoBaseCheck
        $error("IO_BASE overlaps the RAM address range");
    end

    bus_state_t        state, stateNext;
    logic [DATA_W-1:0] addrReg, addrNext;
    logic [DATA_W-1:0] outReg, outNext;
    logic [DATA_W-1:0] ledsReg, ledsNext;
    logic              errReg, errNext;
    logic              ramWe;
    logic [DATA_W-1:0] ramRData;

    logic              isRam, isSw, isLed, unmapped;
    logic              readReq, writeReq, conflict;
    logic [DATA_W-1:0] target;

    sysbus_ram #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) uRam (
        .Clock (Clock),
        .We    (ramWe),
        .Addr  (addrReg[ADDR_W-1:0]),
        .WData (bus.SysBusIn),
        .RData (ramRData)
    );

    always_comb begin
        isRam    = (addrReg[DATA_W-1:ADDR_W] == '0);
        isSw     = (addrReg == SW_ADDR);
        isLed    = (addrReg == LED_ADDR);
        unmapped = !(isRam || isSw || isLed);
        if (isRam)      target = ramRData;
        else if (isSw)  target = Switches;
        else if (isLed) target = ledsReg;
        else            target = '0;
    end

    assign readReq  = !bus.nME && !bus.nOE &&  bus.nWE;
    assign writeReq = !bus.nME &&  bus.nOE && !bus.nWE;
    assign conflict = !bus.nME && !bus.nOE && !bus.nWE;

    always_ff @(posedge Clock or negedge nReset) begin
        if (!nReset) begin
            state   <= IDLE;
            addrReg <= '0;
            outReg  <= '0;
            ledsReg <= '0;
            errReg  <= 1'b0;
        end else begin
            state   <= stateNext;
            addrReg <= addrNext;
            outReg  <= outNext;
            ledsReg <= ledsNext;
            errReg  <= errNext;
        end
    end

    // ALE wins over any strobe. A write commits only on leaving ADDR/READ,
    // so a strobe held across WDONE cannot write twice.
    always_comb begin
        stateNext = state;
        addrNext  = addrReg;
        outNext   = outReg;
        ledsNext  = ledsReg;
        errNext   = 1'b0;
        ramWe     = 1'b0;
        if (bus.ALE) begin
            addrNext  = bus.SysBusIn;
            stateNext = ADDR;
        end else begin
            case (state)
                ADDR, READ: begin
                    if (conflict) begin
                        stateNext = IDLE;
                        errNext   = 1'b1;
                    end else if (readReq) begin
                        stateNext = READ;
                        outNext   = target;
                        if (state == ADDR && unmapped) errNext = 1'b1;
                    end else if (writeReq) begin
                        stateNext = WDONE;
                        ramWe     = isRam;
                        if (isLed) ledsNext = bus.SysBusIn;
                        if (unmapped) errNext = 1'b1;
                    end else begin
                        stateNext = ADDR;
                    end
                end
                WDONE: begin
                    if (conflict) begin
                        stateNext = IDLE;
                        errNext   = 1'b1;
                    end else if (bus.nME) begin
                        stateNext = IDLE;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.SysBusOut = outReg;
    assign bus.SysBusOe  = (state == READ) && !bus.ALE && !bus.nME && !bus.nOE && bus.nWE;
    assign Leds          = ledsReg;
    assign BusErr        = errReg;
    assign StateDbg      = state;

endmodule

// File: tb/tb_sysbus_mem_responder.sv
// Directed bench for sysbus_mem_responder with a RAM model and expected-value queue.
module tb_sysbus_mem_responder;
    import sysbus_mem_responder_pkg::*;

    localparam int DW = 16;

    logic          Clock = 1'b0;
    logic          nReset;
    logic [DW-1:0] Switches;
    logic [DW-1:0] Leds;
    logic          BusErr;
    bus_state_t    StateDbg;

    sysbus_mem_responder_if #(.DATA_W(DW)) bus();

    sysbus_mem_responder #(.ADDR_W(10), .DATA_W(DW), .IO_BASE(16'hFFF0)) dut (
        .Clock    (Clock),
        .nReset   (nReset),
        .bus      (bus.slave),
        .Switches (Switches),
        .Leds     (Leds),
        .BusErr   (BusErr),
        .StateDbg (StateDbg)
    );

    // clock / reset
    always #5 Clock = ~Clock;

    int            numChecks = 0;
    int            numErrors = 0;
    logic [DW-1:0] memModel [int];
    logic [DW-1:0] exp_q[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        numChecks++;
        if (got !== exp) begin
            numErrors++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    // driver tasks
    task automatic step();
        @(posedge Clock);
        #1;
    endtask

    task automatic idleBus();
        bus.ALE = 1'b0;
        bus.nME = 1'b1;
        bus.nOE = 1'b1;
        bus.nWE = 1'b1;
    endtask

    task automatic aleCycle(input logic [DW-1:0] addr);
        idleBus();
        bus.ALE      = 1'b1;
        bus.SysBusIn = addr;
        step();
        bus.ALE = 1'b0;
    endtask

    task automatic writeWord(input logic [DW-1:0] addr, input logic [DW-1:0] data);
        aleCycle(addr);
        bus.nME      = 1'b0;
        bus.nWE      = 1'b0;
        bus.SysBusIn = data;
        step();
        idleBus();
        step();
        if (addr < 16'd1024) memModel[int'(addr)] = data;
    endtask

    task automatic readWord(input logic [DW-1:0] addr, output logic [DW-1:0] data);
        aleCycle(addr);
        bus.nME = 1'b0;
        bus.nOE = 1'b0;
        step();
        check("rd_oe", bus.SysBusOe, 1'b1);
        data = bus.SysBusOut;
        idleBus();
        step();
    endtask

    initial begin
        #200000;
        check("watchdog", 1'b1, 1'b0);
        $display("Simulation finished: %0d checks, %0d errors", numChecks, numErrors);
        $finish;
    end

    initial begin
        logic [DW-1:0] rd;
        logic [DW-1:0] addr;
        logic [DW-1:0] addrs[$];

        Switches     = '0;
        bus.SysBusIn = '0;
        idleBus();
        nReset = 1'b0;
        #12;
        check("rst_out",   bus.SysBusOut, 16'h0000);
        check("rst_oe",    bus.SysBusOe, 1'b0);
        check("rst_leds",  Leds, 16'h0000);
        check("rst_err",   BusErr, 1'b0);
        check("rst_state", StateDbg, IDLE);
        @(negedge Clock);
        nReset = 1'b1;
        step();

        // write then read RAM, cycle by cycle
        aleCycle(16'h0012);
        check("ale_state", StateDbg, ADDR);
        bus.nME = 1'b0; bus.nWE = 1'b0; bus.SysBusIn = 16'hBEEF;
        step();
        check("wr_state", StateDbg, WDONE);
        idleBus();
        step();
        check("wr_idle", StateDbg, IDLE);
        memModel[16'h12] = 16'hBEEF;
        aleCycle(16'h0012);
        bus.nME = 1'b0; bus.nOE = 1'b0;
        #1;
        check("rd_oe_first", bus.SysBusOe, 1'b0);
        step();
        check("rd_oe_second", bus.SysBusOe, 1'b1);
        check("rd_data", bus.SysBusOut, 16'hBEEF);
        bus.nOE = 1'b1;
        #1;
        check("rd_oe_release", bus.SysBusOe, 1'b0);
        idleBus();
        step();

        // LED write, switch read with live tracking
        aleCycle(16'hFFF1);
        bus.nME = 1'b0; bus.nWE = 1'b0; bus.SysBusIn = 16'h00A5;
        step();
        check("led_write", Leds, 16'h00A5);
        idleBus();
        step();
        Switches = 16'h1234;
        aleCycle(16'hFFF0);
        bus.nME = 1'b0; bus.nOE = 1'b0;
        step();
        check("sw_read", bus.SysBusOut, 16'h1234);
        Switches = 16'h4321;
        #1;
        check("sw_hold", bus.SysBusOut, 16'h1234);
        step();
        check("sw_track", bus.SysBusOut, 16'h4321);
        idleBus();
        step();
        readWord(16'hFFF1, rd);
        check("led_read", rd, 16'h00A5);
        writeWord(16'hFFF0, 16'hDEAD);
        check("sw_wr_noerr", BusErr, 1'b0);
        check("sw_wr_leds", Leds, 16'h00A5);

        // held write: single commit of the first data word
        aleCycle(16'h0005);
        bus.nME = 1'b0; bus.nWE = 1'b0; bus.SysBusIn = 16'h1111;
        step();
        bus.SysBusIn = 16'h2222;
        step();
        step();
        idleBus();
        step();
        memModel[5] = 16'h1111;
        readWord(16'h0005, rd);
        check("held_write", rd, 16'h1111);

        // scoreboard pass over random RAM words
        writeWord(16'h0000, 16'h0101);
        for (int i = 0; i < 6; i++) begin
            addr = DW'($urandom_range(1023, 1));
            addrs.push_back(addr);
            writeWord(addr, DW'($urandom_range(16'hFFFF, 0)));
        end
        foreach (addrs[i]) exp_q.push_back(memModel[int'(addrs[i])]);
        foreach (addrs[i]) begin
            readWord(addrs[i], rd);
            check("sb_read", rd, exp_q.pop_front());
        end

        // conflict
        aleCycle(16'h0005);
        bus.nME = 1'b0; bus.nOE = 1'b0; bus.nWE = 1'b0; bus.SysBusIn = 16'h7777;
        #1;
        check("cfl_oe", bus.SysBusOe, 1'b0);
        step();
        check("cfl_err", BusErr, 1'b1);
        check("cfl_state", StateDbg, IDLE);
        idleBus();
        step();
        check("cfl_err_pulse", BusErr, 1'b0);
        readWord(16'h0005, rd);
        check("cfl_ram", rd, 16'h1111);

        // unmapped read and write
        aleCycle(16'h8000);
        bus.nME = 1'b0; bus.nOE = 1'b0;
        step();
        check("unm_rd_data", bus.SysBusOut, 16'h0000);
        check("unm_rd_err", BusErr, 1'b1);
        step();
        check("unm_rd_pulse", BusErr, 1'b0);
        idleBus();
        step();
        aleCycle(16'h8000);
        bus.nME = 1'b0; bus.nWE = 1'b0; bus.SysBusIn = 16'h3333;
        step();
        check("unm_wr_err", BusErr, 1'b1);
        idleBus();
        step();

        // ALE aborts a read in progress
        aleCycle(16'h0012);
        bus.nME = 1'b0; bus.nOE = 1'b0;
        step();
        check("abort_oe_pre", bus.SysBusOe, 1'b1);
        bus.ALE = 1'b1; bus.SysBusIn = 16'h0005;
        #1;
        check("abort_oe", bus.SysBusOe, 1'b0);
        step();
        bus.ALE = 1'b0;
        check("abort_state", StateDbg, ADDR);
        step();
        check("abort_newaddr", bus.SysBusOut, 16'h1111);
        idleBus();
        step();

        // reset during WDONE, then strobes without ALE
        aleCycle(16'hFFF1);
        bus.nME = 1'b0; bus.nWE = 1'b0; bus.SysBusIn = 16'h5A5A;
        step();
        check("wdone_leds", Leds, 16'h5A5A);
        bus.SysBusIn = 16'hFFFF;
        #2 nReset = 1'b0;
        #1;
        check("arst_leds",  Leds, 16'h0000);
        check("arst_out",   bus.SysBusOut, 16'h0000);
        check("arst_oe",    bus.SysBusOe, 1'b0);
        check("arst_state", StateDbg, IDLE);
        @(negedge Clock);
        nReset = 1'b1;
        step();
        step();
        check("post_rst_leds",  Leds, 16'h0000);
        check("post_rst_state", StateDbg, IDLE);
        idleBus();
        bus.nME = 1'b0; bus.nOE = 1'b0;
        step();
        check("post_rst_rd_oe",  bus.SysBusOe, 1'b0);
        check("post_rst_rd_out", bus.SysBusOut, 16'h0000);
        idleBus();
        step();
        readWord(16'h0000, rd);
        check("post_rst_ram", rd, memModel[0]);

        $display("Simulation finished: %0d checks, %0d errors", numChecks, numErrors);
        $finish;
    end

endmodule

// File: doc/sysbus_mem_responder.md
Name: sysbus_mem_responder

Overview:
- Memory-side responder for the multiplexed 16-bit SysBus driven by the CPU control FSM.
- Latches the address on ALE, then serves active-low read (nOE) and write (nWE) strobes qualified by nME.
- Targets are a word RAM and two memory-mapped I/O registers: switches (read-only) and LEDs (read/write).
- Sits between the CPU pad/bus logic and the on-chip memory map.

Parameters:
- ADDR_W, 10: RAM word-address width. The RAM occupies addresses 0 .. 2^ADDR_W-1.
- IO_BASE, 16'hFFF0: base address of the I/O block. IO_BASE+0 = switches (RO), IO_BASE+1 = LED register (RW).
- DATA_W, 16: SysBus and word width.

Ports:
- Clock  in  1  system clock, all state updates on posedge.
- nReset  in  1  reset, asynchronous, active-low.
- SysBusIn  in  DATA_W  bus value, carries the address in the ALE cycle and data otherwise.
- SysBusOut  out  DATA_W  read data driven toward the bus.
- SysBusOe  out  1  tristate enable for SysBusOut. When 1 the responder owns the bus.
- ALE  in  1  address latch enable, active-high.
- nME  in  1  memory enable, active-low.
- nOE  in  1  output enable (read strobe), active-low.
- nWE  in  1  write enable, active-low.
- Switches  in  DATA_W  external switch inputs, readable at IO_BASE.
- Leds  out  DATA_W  LED register.
- BusErr  out  1  one-cycle pulse on a protocol error.

Behaviour:
- Reset values: SysBusOut=0, SysBusOe=0, Leds=0, BusErr=0, AddrReg=0, state=IDLE. RAM contents are not reset. Reset mid-transaction aborts it immediately: no write commits and the bus is released.
- States: IDLE, ADDR, READ, WDONE.
- Address phase: posedge with ALE=1 -> AddrReg<=SysBusIn, state->ADDR. This applies from any state. ALE overrides everything else and aborts any in-progress transaction; SysBusOe drops in that same cycle.
- Strobe decode, sampled at posedge in ADDR, READ or WDONE with ALE=0:
  - Read request: nME=0, nOE=0, nWE=1.
  - Write request: nME=0, nWE=0, nOE=1.
  - Conflict: nME=0, nOE=0, nWE=0.
- ADDR + read request -> READ:
  - SysBusOut<=target(AddrReg).
  - Read latency is 1 cycle: data is valid in the cycle after nOE is first sampled low.
- READ:
  - SysBusOe = (state==READ) & !nME & !nOE, decoded combinationally from the registered state. It therefore releases in the same cycle nOE or nME deasserts.
  - SysBusOut re-samples target(AddrReg) every cycle, so a live switch value is tracked.
- ADDR + write request -> WDONE:
  - Exactly one commit per address phase: RAM[AddrReg]<=SysBusIn, or Leds<=SysBusIn at IO_BASE+1.
  - Further write cycles in WDONE are ignored, which covers the CPU holding nWE low across stages.
- Conflict:
  - No commit and no drive.
  - BusErr=1 for one cycle, state->IDLE.
- nME=1 with ALE=0 in ADDR or READ: stay in ADDR, SysBusOe=0. In WDONE: -> IDLE.
- IDLE ignores all strobes. A strobe without a preceding ALE never reads or writes.
- Address decode:
  - AddrReg < 2^ADDR_W -> RAM.
  - AddrReg == IO_BASE -> Switches. Writes to it are dropped silently.
  - AddrReg == IO_BASE+1 -> Leds.
  - Any other address: reads return 16'h0000, writes are dropped, BusErr pulses once on the strobe cycle.
- Parameter constraint: IO_BASE must be >= 2^ADDR_W. Check it with an elaboration-time assertion.
- RAM: single-port, synchronous write, combinational or registered read. The 1-cycle read latency is met either way, because SysBusOut is registered here.

Decomposition:
- Add a sysbus package holding:
  - bus_state_t enum (IDLE, ADDR, READ, WDONE).
  - IO offset constants (IO_SW_OFS=0, IO_LED_OFS=1).
  - DATA_W default.
- Sub-module sysbus_ram, parameterised by ADDR_W and DATA_W. Ports: Clock, We, Addr, WData, RData. No reset.
- Decode, FSM and I/O registers stay in the top module.

Test Plan:
- Write then read RAM:
  - Stimulus: ALE with 16'h0012; nME=0, nWE=0 with data 16'hBEEF; nME=1; ALE with 16'h0012; nME=0, nOE=0.
  - Response: SysBusOe=1 and SysBusOut=16'hBEEF from the 2nd nOE cycle. SysBusOe=0 once nOE=1.
- LED and switch I/O:
  - Stimulus: write 16'h00A5 to 16'hFFF1; then set Switches=16'h1234 and read 16'hFFF0.
  - Response: Leds=16'h00A5 on the cycle after the commit. The read returns 16'h1234. Changing Switches to 16'h4321 mid-read appears on SysBusOut one cycle later.
- Held write:
  - Stimulus: nWE low for 3 cycles at address 5, with SysBusIn changing from 16'h1111 to 16'h2222 after the first cycle.
  - Response: RAM[5]=16'h1111. Exactly one commit.
- Errors:
  - Conflict: nOE=0 and nWE=0 together -> one BusErr pulse, no RAM change, SysBusOe=0.
  - Unmapped address: ALE with 16'h8000 then a read -> SysBusOut=16'h0000 and one BusErr pulse.
- Abort:
  - ALE=1 during READ -> SysBusOe=0 that cycle and the new address is latched.
  - nReset low during WDONE -> all outputs at reset values. The strobe without a new ALE that follows has no effect.
